mem_byte_seq: RTL
=================

# mem_byte_seq

Access sequencer sitting between the core's load/store stage and the byte-wide read/write port of the shared 256-byte instruction/data SRAM. It accepts one byte, halfword or word request at a time over a valid/ready handshake and issues it as 1, 2 or 4 sequential byte accesses. Read bytes are gathered into a single right-aligned response. Byte order is big-endian: address offset 0 maps to data bits 31:24.

## Interface
Parameters:
- none; widths are fixed by the 8-bit SRAM address space.

Ports:
- clk  in  1  rising-edge clock, shared with the SRAM
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_addr  in  8  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  single-cycle completion pulse; no backpressure
- resp_rdata  out  32  load data, right-aligned and zero-extended; 0 for stores
- resp_err  out  1  misaligned request; see Configuration
- rw_addr  out  8  SRAM byte address
- w  out  8  SRAM write byte
- w_en  out  1  SRAM byte write enable
- r  in  8  SRAM read byte; registered, valid the cycle after rw_addr is presented

## Operation
- Byte count N: 1, 2 or 4, from req_size.
- Base address: req_addr. For half, bit 0 is forced to 0. For word, bits 1:0 are forced to 0. This forcing applies when the alignment check is compiled out.
- Access k (0..N-1):
  - rw_addr = base + k, computed modulo 256. Aligned bases never wrap.
  - Store byte k = req_wdata[8*(N-1-k)+7 : 8*(N-1-k)], so the most significant byte goes first.
- Loads: each captured r byte shifts into an accumulator from the left, MSB first. resp_rdata = accumulator zero-extended to 32 bits.
- FSM states:
  - IDLE:
    - req_ready = 1.
    - On req_valid, latch we, size, base and wdata, then go to ACCESS.
  - ACCESS:
    - Drive rw_addr = base + k for k = 0..N-1. w_en = we.
    - After k = N-1, a store goes to DONE and a load goes to DRAIN.
  - DRAIN (loads only):
    - One cycle to capture the last r byte, then DONE.
  - DONE:
    - resp_valid = 1 for one cycle, then IDLE.
    - req_ready = 0 in DONE. A new request is accepted no earlier than the cycle after resp_valid.
- Outputs outside ACCESS: rw_addr = 0, w = 0, w_en = 0.
- Request inputs are ignored whenever req_ready = 0.
- Reset values: state IDLE; req_ready 1; resp_valid, resp_rdata, resp_err, rw_addr, w, w_en all 0.
- Reset during ACCESS or DRAIN: the transfer aborts immediately and no response is issued. Bytes already written stay in the SRAM.

## Timing
- Cycle 0 is the cycle in which req_valid & req_ready is high.
- Store: w_en is high in cycles 1..N. resp_valid is in cycle N+1. Word store: resp_valid in cycle 5.
- Load: rw_addr is driven in cycles 1..N. Byte k is sampled from r at the end of cycle k+2. resp_valid and resp_rdata are in cycle N+2. Word load: resp_valid in cycle 6.
- resp_rdata and resp_err hold their value until the next resp_valid.
- Maximum throughput: one word store per 6 cycles, one word load per 7 cycles.

## Configuration
- ALIGN_CHECK_EN defined:
  - A half request with addr[0] = 1, or a word request with addr[1:0] ≠ 00, makes no SRAM access.
  - The FSM goes IDLE → DONE, giving resp_valid in cycle 1 with resp_err = 1 and resp_rdata = 0.
- ALIGN_CHECK_EN undefined:
  - Low address bits are forced to zero as described in Operation.
  - resp_err is tied to 0.

## Structure
- Shared package mem_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state enum (IDLE, ACCESS, DRAIN, DONE);
  - the byte-count function.
- One sub-module, mem_byte_lane: combinational. Maps (size, k, wdata) to the store byte and computes N. It is shared with the future fetch-side sequencer.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load at 0x10:
  - Store: w_en in cycles 1–4 with w = DE, AD, BE, EF at 0x10–0x13; resp_valid in cycle 5.
  - Load: resp_rdata = 0xDEADBEEF in cycle 6.
- Byte load at 0x12 after the above → resp_rdata = 0x000000BE, resp_valid in cycle 3.
- Half store 0x1234 at 0x22, then word load at 0x20, with 0x20–0x21 preloaded as 0x0000 → 0x00001234.
- Misaligned word load at 0x13:
  - With ALIGN_CHECK_EN: resp_err = 1 and resp_rdata = 0 in cycle 1, w_en never asserted.
  - Without it: reads 0x10–0x13, resp_err = 0.
- Back-to-back: hold req_valid through a word store followed by a byte store at 0xFF. req_ready is low in cycles 1–5, the second request is accepted in cycle 6, and 0xFF is written with no wrap.
- Assert rst in cycle 2 of a word store → only byte 0 is written, all outputs are 0 immediately, and no resp_valid is issued.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the byte-serial SRAM access sequencers.
// Holds the request size encodings, the sequencer FSM state type and the
// helpers that turn a request size into a byte count and an aligned base.
// No ports; imported with "import mem_pkg::*;".
package mem_pkg;

  // Request size encodings; 2'b11 is treated exactly like a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Number of SRAM byte accesses a request of the given size needs.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_BYTE: byte_count = 3'd1;
      SZ_HALF: byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

  // Clears the low address bits a half/word access cannot use.
  function automatic logic [7:0] align_base(input logic [1:0] size,
                                            input logic [7:0] addr);
    case (size)
      SZ_BYTE: align_base = addr;
      SZ_HALF: align_base = {addr[7:1], 1'b0};
      default: align_base = {addr[7:2], 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_seq_if.sv
// mem_byte_seq_if: request/response handshake between the load/store stage
// (master) and the byte sequencer (slave).
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_size             SZ_BYTE / SZ_HALF / SZ_WORD (11 = word)
//   req_addr             byte address
//   req_wdata            store data, right-aligned
//   resp_valid           one-cycle completion pulse, no backpressure
//   resp_rdata           load data, right-aligned, zero-extended
//   resp_err             misaligned request flag
interface mem_byte_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_byte_lane.sv
// mem_byte_lane: combinational byte-lane selector for big-endian serial
// access. Given a request size, the access index k and right-aligned store
// data, returns the store byte for access k (MSB first) and the byte count.
//   size        request size encoding
//   k           access index, 0..N-1
//   wdata       right-aligned store data
//   store_byte  wdata byte to write on access k
//   n           number of byte accesses (1, 2 or 4)
module mem_byte_lane
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  k,
  input  logic [31:0] wdata,
  output logic [7:0]  store_byte,
  output logic [2:0]  n
);

  logic [1:0] idx;

  // Access k carries byte N-1-k of the right-aligned data, so the most
  // significant byte of the operand goes out first.
  always_comb begin
    n = byte_count(size);
    case (size)
      SZ_BYTE: idx = 2'd0;
      SZ_HALF: idx = 2'd1 - k;
      default: idx = 2'd3 - k;
    endcase
    store_byte = wdata[{idx, 3'b000} +: 8];
  end

endmodule

// File: rtl/mem_byte_seq.sv
// mem_byte_seq: sequencer between the load/store stage and the byte-wide
// port of the shared 256-byte SRAM. A byte/half/word request is issued as
// 1/2/4 sequential byte accesses, big-endian (offset 0 = bits 31:24); load
// bytes are gathered into one right-aligned, zero-extended response.
//   clk      rising-edge clock, shared with the SRAM
//   rst      asynchronous active-high reset; aborts any transfer in flight
//   bus      mem_byte_seq_if.slave request/response handshake
//   rw_addr  SRAM byte address
//   w        SRAM write byte
//   w_en     SRAM byte write enable
//   r        SRAM read byte, valid the cycle after rw_addr
// Build option: define ALIGN_CHECK_EN to reject misaligned half/word
// requests with resp_err instead of silently aligning them.
module mem_byte_seq
  import mem_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mem_byte_seq_if.slave  bus,
  output logic [7:0]     rw_addr,
  output logic [7:0]     w,
  output logic           w_en,
  input  logic [7:0]     r
);

  state_t      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic [7:0]  base_q;
  logic [31:0] wdata_q;
  logic [1:0]  k_q;
  logic [23:0] acc_q;

  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic [1:0]  lane_size;
  logic [1:0]  lane_k;
  logic [31:0] lane_wdata;
  logic [7:0]  lane_byte;
  logic [2:0]  lane_n;
  logic        last;
  logic        misaligned;
  logic [7:0]  base;

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

`ifdef ALIGN_CHECK_EN
  assign misaligned = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign base = align_base(bus.req_size, bus.req_addr);

  // Outputs are registered, so the lane selector looks one access ahead:
  // in IDLE it sees the incoming request at k=0, in ACCESS the latched
  // request at k+1.
  always_comb begin
    lane_size  = size_q;
    lane_k     = k_q + 2'd1;
    lane_wdata = wdata_q;
    if (state == IDLE) begin
      lane_size  = bus.req_size;
      lane_k     = 2'd0;
      lane_wdata = bus.req_wdata;
    end
  end

  mem_byte_lane u_lane (
    .size       (lane_size),
    .k          (lane_k),
    .wdata      (lane_wdata),
    .store_byte (lane_byte),
    .n          (lane_n)
  );

  assign last = ({1'b0, k_q} == (lane_n - 3'd1));

  // Read data trails the address by one cycle: during ACCESS with k>0 the
  // byte for k-1 is on r, and DRAIN catches the final byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      base_q       <= 8'h00;
      wdata_q      <= 32'h0;
      k_q          <= 2'd0;
      acc_q        <= 24'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      rw_addr      <= 8'h00;
      w            <= 8'h00;
      w_en         <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            if (misaligned) begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 32'h0;
              resp_err_q   <= 1'b1;
            end else begin
              state   <= ACCESS;
              we_q    <= bus.req_we;
              size_q  <= bus.req_size;
              base_q  <= base;
              wdata_q <= bus.req_wdata;
              k_q     <= 2'd0;
              acc_q   <= 24'h0;
              rw_addr <= base;
              w       <= bus.req_we ? lane_byte : 8'h00;
              w_en    <= bus.req_we;
            end
          end
        end
        ACCESS: begin
          if (k_q != 2'd0) begin
            acc_q <= {acc_q[15:0], r};
          end
          if (last) begin
            rw_addr <= 8'h00;
            w       <= 8'h00;
            w_en    <= 1'b0;
            if (we_q) begin
              state        <= DONE;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 32'h0;
              resp_err_q   <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else begin
            k_q     <= k_q + 2'd1;
            rw_addr <= base_q + {6'b000000, lane_k};
            w       <= we_q ? lane_byte : 8'h00;
          end
        end
        DRAIN: begin
          state        <= DONE;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= {acc_q, r};
          resp_err_q   <= 1'b0;
        end
        DONE: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
